// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder for UART tx/rx and performance counters in the 0x8xxx_xxxx region.
// Loads return on rdata one cycle after req_re, matching the synchronous data memory.
module mmio_io_responder #(
    parameter int          RX_FIFO_DEPTH = 8,
    parameter logic [3:0]  IO_REGION     = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wbe,
    input  logic        req_re,
    output logic [31:0] rdata,
    input  logic        instr_retired,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_FIFO_DEPTH);

    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_RXD   = 8'h04;
    localparam logic [7:0] OFF_TXD   = 8'h08;
    localparam logic [7:0] OFF_CYC   = 8'h10;
    localparam logic [7:0] OFF_INS   = 8'h14;
    localparam logic [7:0] OFF_CLR   = 8'h18;

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          tx_overrun;
    logic [31:0]   cyc_cnt;
    logic [31:0]   ins_cnt;

    logic        sel;
    logic [7:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic        empty;
    logic        push;
    logic        pop;
    logic        tx_wr;
    logic        ctrl_rd;
    logic        cnt_clr;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign sel     = (req_addr[31:28] == IO_REGION);
    assign off     = req_addr[7:0];
    assign wr_en   = sel && (req_wbe != 4'h0);
    assign rd_en   = sel && req_re;
    assign empty   = (count == '0);
    assign uart_rx_ready = (count != FULL_CNT);
    assign push    = uart_rx_valid && uart_rx_ready;
    assign pop     = rd_en && (off == OFF_RXD) && !empty;
    assign tx_wr   = wr_en && (off == OFF_TXD);
    assign ctrl_rd = rd_en && (off == OFF_CTRL);
    assign cnt_clr = wr_en && (off == OFF_CLR);
    assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

    // Unselected loads and unmapped offsets read as zero.
    always_comb begin
        rd_val = 32'h0;
        if (sel) begin
            case (off)
                OFF_CTRL: rd_val = {29'h0, tx_overrun, !empty, !uart_tx_valid};
                OFF_RXD:  rd_val = empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr]};
                OFF_CYC:  rd_val = cyc_cnt;
                OFF_INS:  rd_val = ins_cnt;
                default:  rd_val = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (req_re) begin
            rdata <= rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh overrun in the same cycle as a control read stays flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h0;
            tx_overrun    <= 1'b0;
        end else begin
            if (uart_tx_valid && uart_tx_ready) uart_tx_valid <= 1'b0;
            if (ctrl_rd) tx_overrun <= 1'b0;
            if (tx_wr) begin
                if (!uart_tx_valid) begin
                    uart_tx_data  <= req_wdata[7:0];
                    uart_tx_valid <= 1'b1;
                end else begin
                    tx_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= 32'h0;
            ins_cnt <= 32'h0;
        end else if (cnt_clr) begin
            cyc_cnt <= 32'h0;
            ins_cnt <= 32'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'h1;
            if (instr_retired) ins_cnt <= ins_cnt + 32'h1;
        end
    end
endmodule
